// File: rtl/bkm_data_step_chk.sv
// -----------------------------------------------------------------------------
// bkm_data_step_chk
//
// Self-checking comparator for one BKM data-path iteration
// (X_n, Y_n -> X_np1, Y_np1). It compares the DUT results with the golden
// values from the bench and reports:
//   - a signed delta per axis,
//   - a warning flag when the mismatch is small,
//   - an error flag when the mismatch is large or the digit is illegal,
//   - a saturating count of error cycles.
// The control-path (u, v) twin is this same block instantiated with W = WC.
//
// Parameters
//   W      data word width (X, Y, delta)
//   LOG2N  width of iteration index tb_n
//   TOL    largest |delta| (in LSBs) that is reported as a warning, not an error
//   CNTW   width of the error counter
//
// Ports
//   clk                 rising-edge clock
//   arst_n              asynchronous reset, active low
//   srst                synchronous reset, active high; takes priority over enable
//   enable              sample/compare strobe
//   tb_mode, tb_format  BKM mode and number format (informational only)
//   tb_n                iteration index (used only in messages)
//   tb_d_x_n, tb_d_y_n  digits: 00 = 0, 01 = +1, 11 = -1, 10 = illegal
//   tb_X_n, tb_Y_n      golden iteration inputs (informational only)
//   tb_X_np1, tb_Y_np1  golden iteration outputs
//   res_X_np1,res_Y_np1 DUT iteration outputs
//   war_X/Y, err_X/Y    per-axis warning and error flags (registered)
//   delta_X/Y           res - golden, two's complement (registered)
//   err_cnt             cycles with err_X|err_Y, saturating (registered)
//
// Optional feature
//   BKM_CHK_DISPLAY_EN  When defined, every enabled error cycle prints the time,
//                       tb_n, the digits, the golden value, the result and the
//                       delta (in decimal). Flag and counter behaviour does not
//                       change.
// -----------------------------------------------------------------------------
module bkm_data_step_chk #(
    parameter int W     = 64,
    parameter int LOG2N = 6,
    parameter int TOL   = 1,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             srst,
    input  logic             enable,
    input  logic             tb_mode,
    input  logic [1:0]       tb_format,
    input  logic [LOG2N-1:0] tb_n,
    input  logic [1:0]       tb_d_x_n,
    input  logic [1:0]       tb_d_y_n,
    input  logic [W-1:0]     tb_X_n,
    input  logic [W-1:0]     tb_Y_n,
    input  logic [W-1:0]     tb_X_np1,
    input  logic [W-1:0]     tb_Y_np1,
    input  logic [W-1:0]     res_X_np1,
    input  logic [W-1:0]     res_Y_np1,
    output logic             war_X,
    output logic             war_Y,
    output logic             err_X,
    output logic             err_Y,
    output logic [W-1:0]     delta_X,
    output logic [W-1:0]     delta_Y,
    output logic [CNTW-1:0]  err_cnt
);

    localparam logic [W-1:0]    TOL_W   = W'(TOL);
    localparam logic [CNTW-1:0] CNT_MAX = '1;

    // These inputs are informational. They never affect pass or fail.
    logic unused_inputs;
    assign unused_inputs = ^{tb_mode, tb_format, tb_n, tb_X_n, tb_Y_n};

    // Axis 0 is X and axis 1 is Y. Both axes are evaluated by the same logic.
    logic [1:0][W-1:0] res_a;
    logic [1:0][W-1:0] gold_a;
    logic [1:0][1:0]   dig_a;
    logic [1:0][W-1:0] delta_next;
    logic [1:0]        war_next;
    logic [1:0]        err_next;

    assign res_a  = {res_Y_np1, res_X_np1};
    assign gold_a = {tb_Y_np1, tb_X_np1};
    assign dig_a  = {tb_d_y_n, tb_d_x_n};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_axis
            logic [W-1:0] diff;
            logic [W-1:0] mag;
            logic         illegal;
            logic         beyond;

            assign diff = res_a[gi] - gold_a[gi];

            // Two's-complement magnitude. For -2^(W-1) the negation gives the
            // same value, so its MSB is still set. That case is therefore
            // always treated as outside the tolerance.
            assign mag     = diff[W-1] ? (-diff) : diff;
            assign illegal = (dig_a[gi] == 2'b10);
            assign beyond  = mag[W-1] || (mag > TOL_W);

            assign delta_next[gi] = diff;
            assign err_next[gi]   = illegal | beyond;
            assign war_next[gi]   = ~illegal & ~beyond & (diff != '0);
        end
    endgenerate

    logic [1:0]        war_reg;
    logic [1:0]        err_reg;
    logic [1:0][W-1:0] delta_reg;
    logic [CNTW-1:0]   cnt_reg;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            war_reg   <= '0;
            err_reg   <= '0;
            delta_reg <= '0;
            cnt_reg   <= '0;
        end else if (srst) begin
            war_reg   <= '0;
            err_reg   <= '0;
            delta_reg <= '0;
            cnt_reg   <= '0;
        end else if (enable) begin
            war_reg   <= war_next;
            err_reg   <= err_next;
            delta_reg <= delta_next;
            if ((|err_next) && (cnt_reg != CNT_MAX)) begin
                cnt_reg <= cnt_reg + CNTW'(1);
            end
        end
    end

    assign war_X   = war_reg[0];
    assign war_Y   = war_reg[1];
    assign err_X   = err_reg[0];
    assign err_Y   = err_reg[1];
    assign delta_X = delta_reg[0];
    assign delta_Y = delta_reg[1];
    assign err_cnt = cnt_reg;

`ifdef BKM_CHK_DISPLAY_EN
    always_ff @(posedge clk) begin
        if (arst_n && !srst && enable && (|err_next)) begin
            $display("bkm_data_step_chk t=%0t n=%0d d_x=%b d_y=%b X gold=%0d res=%0d delta=%0d Y gold=%0d res=%0d delta=%0d",
                     $time, tb_n, tb_d_x_n, tb_d_y_n,
                     $signed(tb_X_np1), $signed(res_X_np1), $signed(delta_next[0]),
                     $signed(tb_Y_np1), $signed(res_Y_np1), $signed(delta_next[1]));
        end
    end
`endif

endmodule

// File: tb/tb_bkm_data_step_chk.sv
module tb_bkm_data_step_chk;

    localparam int W     = 64;
    localparam int LOG2N = 6;
    localparam int TOL   = 1;
    localparam int CNTW  = 8;

    logic             clk = 1'b0;
    logic             arst_n;
    logic             srst;
    logic             enable;
    logic             tb_mode;
    logic [1:0]       tb_format;
    logic [LOG2N-1:0] tb_n;
    logic [1:0]       tb_d_x_n, tb_d_y_n;
    logic [W-1:0]     tb_X_n, tb_Y_n, tb_X_np1, tb_Y_np1, res_X_np1, res_Y_np1;
    logic             war_X, war_Y, err_X, err_Y;
    logic [W-1:0]     delta_X, delta_Y;
    logic [CNTW-1:0]  err_cnt;

    always #5 clk = ~clk;

    bkm_data_step_chk #(.W(W), .LOG2N(LOG2N), .TOL(TOL), .CNTW(CNTW)) dut (
        .clk(clk), .arst_n(arst_n), .srst(srst), .enable(enable),
        .tb_mode(tb_mode), .tb_format(tb_format), .tb_n(tb_n),
        .tb_d_x_n(tb_d_x_n), .tb_d_y_n(tb_d_y_n),
        .tb_X_n(tb_X_n), .tb_Y_n(tb_Y_n),
        .tb_X_np1(tb_X_np1), .tb_Y_np1(tb_Y_np1),
        .res_X_np1(res_X_np1), .res_Y_np1(res_Y_np1),
        .war_X(war_X), .war_Y(war_Y), .err_X(err_X), .err_Y(err_Y),
        .delta_X(delta_X), .delta_Y(delta_Y), .err_cnt(err_cnt)
    );

    int checks   = 0;
    int failures = 0;
    int txn      = 0;

    // Expected (reference model) output state
    logic        e_war_x, e_war_y, e_err_x, e_err_y;
    logic [63:0] e_dx, e_dy;
    int          e_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s txn=%0d got=%0h exp=%0h", tag, txn, got, exp);
        end
    endtask

    // One axis, straight from the classification rules, in signed arithmetic
    function automatic void axis_model(input logic [63:0] res, input logic [63:0] gold,
                                       input logic [1:0] dig, output logic war,
                                       output logic err, output logic [63:0] dl);
        longint sd;
        longint mag;
        dl  = res - gold;
        sd  = longint'(dl);
        war = 1'b0;
        err = 1'b0;
        if (dig == 2'b10) begin
            err = 1'b1;
        end else if (sd == 0) begin
            // exact match
        end else if (dl == 64'h8000_0000_0000_0000) begin
            err = 1'b1;
        end else begin
            mag = (sd < 0) ? -sd : sd;
            if (mag <= longint'(TOL)) war = 1'b1;
            else                      err = 1'b1;
        end
    endfunction

    task automatic model_clear();
        e_war_x = 0; e_war_y = 0; e_err_x = 0; e_err_y = 0;
        e_dx = 0; e_dy = 0; e_cnt = 0;
    endtask

    task automatic check_all();
        check("war_X",   64'(war_X),   64'(e_war_x));
        check("war_Y",   64'(war_Y),   64'(e_war_y));
        check("err_X",   64'(err_X),   64'(e_err_x));
        check("err_Y",   64'(err_Y),   64'(e_err_y));
        check("delta_X", delta_X,      e_dx);
        check("delta_Y", delta_Y,      e_dy);
        check("err_cnt", 64'(err_cnt), 64'(e_cnt));
    endtask

    // One clock transaction: drive the inputs, clock them in, update the
    // model, and compare #1 after the edge.
    task automatic cycle(input logic en, input logic sr,
                         input logic [1:0] dx, input logic [1:0] dy,
                         input logic [63:0] gx, input logic [63:0] rx,
                         input logic [63:0] gy, input logic [63:0] ry);
        logic wx, ex, wy, ey;
        logic [63:0] ddx, ddy;
        enable = en; srst = sr;
        tb_d_x_n = dx; tb_d_y_n = dy;
        tb_X_np1 = gx; res_X_np1 = rx; tb_Y_np1 = gy; res_Y_np1 = ry;
        tb_mode = 1'($urandom); tb_format = 2'($urandom); tb_n = LOG2N'($urandom);
        tb_X_n = {$urandom, $urandom}; tb_Y_n = {$urandom, $urandom};
        @(posedge clk);
        if (sr) begin
            model_clear();
        end else if (en) begin
            axis_model(rx, gx, dx, wx, ex, ddx);
            axis_model(ry, gy, dy, wy, ey, ddy);
            e_war_x = wx; e_err_x = ex; e_dx = ddx;
            e_war_y = wy; e_err_y = ey; e_dy = ddy;
            if ((ex || ey) && e_cnt < (1 << CNTW) - 1) e_cnt++;
        end
        #1;
        txn++;
        $display("txn %0d en=%0b srst=%0b dx=%b dy=%b dX=%0d dY=%0d warX=%0b errX=%0b warY=%0b errY=%0b cnt=%0d",
                 txn, en, sr, dx, dy, $signed(delta_X), $signed(delta_Y),
                 war_X, err_X, war_Y, err_Y, err_cnt);
        check_all();
    endtask

    function automatic logic [63:0] pick_res(input logic [63:0] gold);
        case ($urandom_range(0, 7))
            0:       return gold;
            1:       return gold + 64'd1;
            2:       return gold - 64'd1;
            3:       return gold + 64'd2;
            4:       return gold - 64'd2;
            5:       return gold + 64'h8000_0000_0000_0000;
            6:       return gold - 64'd1000;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        logic [63:0] gx, gy;
        arst_n = 1'b0; srst = 1'b0; enable = 1'b0;
        tb_mode = 0; tb_format = 0; tb_n = 0; tb_d_x_n = 0; tb_d_y_n = 0;
        tb_X_n = 0; tb_Y_n = 0; tb_X_np1 = 0; tb_Y_np1 = 0; res_X_np1 = 0; res_Y_np1 = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 check_all();
        @(negedge clk) arst_n = 1'b1;

        // Directed cases
        cycle(1, 0, 2'b00, 2'b00, 64'd100, 64'd100, 64'd50, 64'd50);    // exact match
        cycle(1, 0, 2'b01, 2'b00, 64'd100, 64'd101, 64'd50, 64'd50);    // +1 gives a warning
        check("delta_X_plus1", delta_X, 64'd1);
        cycle(1, 0, 2'b11, 2'b01, 64'd100, 64'd99, 64'd50, 64'd50);     // -1 gives a warning
        check("delta_X_minus1", delta_X, 64'hFFFF_FFFF_FFFF_FFFF);
        cycle(1, 0, 2'b00, 2'b00, 64'd100, 64'd100, 64'd100, 64'd110);  // Y off by 10
        check("delta_Y_10", delta_Y, 64'd10);
        check("cnt_after_first_err", 64'(err_cnt), 64'd1);
        cycle(0, 0, 2'b00, 2'b00, 64'd7, 64'd9, 64'd7, 64'd7);          // hold
        cycle(1, 0, 2'b10, 2'b00, 64'd5, 64'd5, 64'd5, 64'd5);          // illegal d_x
        cycle(1, 0, 2'b00, 2'b10, 64'd5, 64'd6, 64'd5, 64'd5);          // illegal d_y
        cycle(1, 0, 2'b00, 2'b00, 64'd0, 64'h8000_0000_0000_0000, 64'd3, 64'd1); // most-negative magnitude
        cycle(1, 1, 2'b10, 2'b10, 64'd0, 64'd9, 64'd0, 64'd9);          // srst beats enable

        // Randomised traffic
        for (int i = 0; i < 300; i++) begin
            gx = {$urandom, $urandom};
            gy = {$urandom, $urandom};
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0),
                  2'($urandom), 2'($urandom), gx, pick_res(gx), gy, pick_res(gy));
        end

        // Asynchronous reset in mid-cycle, away from a clock edge
        cycle(1, 0, 2'b00, 2'b00, 64'd1, 64'd50, 64'd1, 64'd1);
        @(negedge clk);
        arst_n = 1'b0;
        model_clear();
        #1 check_all();
        @(negedge clk) arst_n = 1'b1;

        // Counter saturation
        for (int i = 0; i < (1 << CNTW) + 5; i++) begin
            cycle(1, 0, 2'b00, 2'b00, 64'd100, 64'd100, 64'd100, 64'd110);
        end
        check("cnt_saturated", 64'(err_cnt), 64'((1 << CNTW) - 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
